// File: rtl/tmma_left_feeder.sv
// tmma_left_feeder: left-edge operand injector for the TMMA PE array.
// Accepts one K column of A per beat and pushes it into the array with a
// systolic skew: row r sees the beat r cycles after row 0. Each element is
// tagged with its K index, the A data-type code and the job precision.
//
// Source handshake: a beat transfers in any cycle where src_valid_i and
// src_ready_o are both 1. src_ready_o depends only on the FSM state (high
// in FEED). src_data_i and src_valid_i are ignored while src_ready_o is 0.
module tmma_left_feeder #(
   parameter int   ROWS   = 4,
   parameter int   DATA_W = 32,
   parameter int   CNT_W  = 8,
   parameter int   PREC_W = 2,
   parameter logic TYPE_A = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic [CNT_W-1:0]         k_len_i,
   input  logic [PREC_W-1:0]        precision_i,
   input  logic                     src_valid_i,
   output logic                     src_ready_o,
   input  logic [ROWS*DATA_W-1:0]   src_data_i,
   output logic [ROWS-1:0]          left_data_valid_o,
   output logic [ROWS*CNT_W-1:0]    left_data_cnt_o,
   output logic [ROWS-1:0]          left_data_type_o,
   output logic [ROWS*PREC_W-1:0]   left_precision_o,
   output logic [ROWS*DATA_W-1:0]   left_data_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [1:0]               dbg_state_o
);

   localparam int DRW = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_k_len;
   logic [CNT_W-1:0]   r_k;
   logic [PREC_W-1:0]  r_prec;
   logic [DRW-1:0]     r_drain;
   logic               w_accept;
   logic               w_last;
   logic               w_drain_end;

   assign w_accept    = src_valid_i && (r_state == S_FEED);
   assign w_last      = w_accept && (r_k == (r_k_len - CNT_W'(1)));
   assign w_drain_end = (r_drain == DRW'(ROWS - 1));

   assign src_ready_o = (r_state == S_FEED);
   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = (r_state == S_DONE);
   assign dbg_state_o = r_state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: a zero-length job skips straight to DONE; the
   // drain phase waits until the last beat has left the deepest row.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_next = (k_len_i == '0) ? S_DONE : S_FEED;
            end
         end
         S_FEED: begin
            if (w_last) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_drain_end) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Job parameters, beat counter and drain counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k_len <= '0;
         r_k     <= '0;
         r_prec  <= '0;
         r_drain <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i && (k_len_i != '0)) begin
                  r_k_len <= k_len_i;
                  r_prec  <= precision_i;
                  r_k     <= '0;
               end
            end
            S_FEED: begin
               if (w_accept) begin
                  r_k <= r_k + CNT_W'(1);
               end
               if (w_last) begin
                  r_drain <= '0;
               end
            end
            S_DRAIN: begin
               r_drain <= r_drain + DRW'(1);
            end
            default: begin
               r_drain <= '0;
            end
         endcase
      end
   end

   // Per-row skew chains. Row r is r+1 registers deep; stage 0 takes the
   // accepted element or a zeroed bubble, so invalid slots never carry
   // stale cnt/data into the array.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic               r_v [0:r];
      logic [CNT_W-1:0]   r_c [0:r];
      logic [DATA_W-1:0]  r_d [0:r];

      // Shift the row's chain every cycle, loading stage 0 from the source.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s <= r; s++) begin
               r_v[s] <= 1'b0;
               r_c[s] <= '0;
               r_d[s] <= '0;
            end
         end else begin
            r_v[0] <= w_accept;
            r_c[0] <= w_accept ? r_k : '0;
            r_d[0] <= w_accept ? src_data_i[r*DATA_W +: DATA_W] : '0;
            for (int s = 1; s <= r; s++) begin
               r_v[s] <= r_v[s-1];
               r_c[s] <= r_c[s-1];
               r_d[s] <= r_d[s-1];
            end
         end
      end

      assign left_data_valid_o[r]                  = r_v[r];
      assign left_data_cnt_o[r*CNT_W +: CNT_W]     = r_c[r];
      assign left_data_o[r*DATA_W +: DATA_W]       = r_d[r];
      assign left_data_type_o[r]                   = r_v[r] ? TYPE_A : 1'b0;
      assign left_precision_o[r*PREC_W +: PREC_W]  = r_v[r] ? r_prec : '0;
   end

endmodule

// File: doc/tmma_left_feeder.md
Name: tmma_left_feeder

Overview:
- Transmit end of the PE-array left-edge interface. Drives the left_data_* inputs of the first PE column, one row per output lane.
- Per job, accepts k_len beats from an A-operand source. Each beat is one K-index column of A, covering all ROWS rows.
- Injects each beat with a systolic skew: row r lags row 0 by r cycles. Tags every element with its K index, data type and precision.
- Sits between the A operand buffer and the array, alongside a matching top-edge feeder.

Parameters:
- ROWS, 4, number of PE rows fed (output lanes).
- DATA_W, 32, width of one element (matches PE input data width).
- CNT_W, 8, K-index width (matches TMMA count width).
- PREC_W, 2, precision code width.
- TYPE_A, 1'b0, data-type code for an A operand.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  job start pulse; sampled only in IDLE.
- k_len_i  in  CNT_W  number of beats in the job; sampled with start_i.
- precision_i  in  PREC_W  job precision; sampled with start_i.
- src_valid_i  in  1  source beat valid.
- src_ready_o  out  1  feeder ready to accept a beat.
- src_data_i  in  ROWS*DATA_W  one K column; row r at bits [r*DATA_W +: DATA_W].
- left_data_valid_o  out  ROWS  per-row valid to the PE array.
- left_data_cnt_o  out  ROWS*CNT_W  per-row K index.
- left_data_type_o  out  ROWS  per-row data type.
- left_precision_o  out  ROWS*PREC_W  per-row precision.
- left_data_o  out  ROWS*DATA_W  per-row element.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all outputs 0, including every skew-pipeline stage, src_ready_o, busy_o and done_o.
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start_i=1 and k_len_i!=0 -> latch k_len and precision, clear beat counter k=0, go to FEED.
  - start_i=1 and k_len_i==0 -> go to DONE directly; no valid is ever emitted.
- FEED:
  - src_ready_o=1.
  - Accept = src_valid_i && src_ready_o. Each accept loads stage 0 with {valid=1, cnt=k, data=src_data_i}, then k increments.
  - A cycle without an accept loads a bubble (valid=0) into stage 0. The skew stays intact; cnt does not advance.
  - When the accept has k==k_len-1 -> go to DRAIN with drain counter 0. src_ready_o is 0 from the next cycle.
- DRAIN: src_ready_o=0. Counts ROWS cycles, then goes to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o is 1 in FEED, DRAIN and DONE.
- Skew and timing:
  - Row r uses a chain of r+1 registers.
  - A beat accepted in cycle c appears on row r during cycle c+1+r, with its valid, cnt and data.
  - For the last beat, done_o is high in cycle c+1+ROWS and busy_o is low from c+2+ROWS.
- left_data_type_o[r]=TYPE_A whenever row r is valid, 0 otherwise. left_precision_o[r] = latched precision whenever valid, 0 otherwise.
- Invalid rows drive data=0 and cnt=0, so the array never sees stale operands.
- start_i is ignored outside IDLE; the latched k_len and precision are unaffected.
- src_data_i and src_valid_i are ignored when src_ready_o=0.
- k_len max is 2^CNT_W-1. cnt never wraps within a job.
- Back-to-back jobs: start_i in the cycle after done_o is accepted. The new job's row 0 may be valid while nothing from the old job remains (already drained).
- Reset mid-job: everything clears immediately, with no done_o pulse. In-flight skewed elements are discarded.

Test Plan:
- ROWS=4, start with k_len=3 and precision=2, src_valid held 1, beats D0..D2 accepted in cycles 1..3 -> row0 valid cycles 2..4 with cnt 0,1,2; row3 valid cycles 5..7; type=TYPE_A; precision=2; done_o in cycle 8; busy_o low at cycle 9.
- Same job with src_valid low in the cycle after D0 -> every row shows a one-cycle valid=0 gap between cnt 0 and cnt 1, shifted by r per row; done_o is delayed by 1 cycle.
- start with k_len=0 -> done_o one cycle later; left_data_valid_o stays 0; src_ready_o never asserts.
- start_i pulsed during FEED with a different k_len and precision -> ignored; original job completes unchanged.
- rst_n dropped while row 2 holds valid data -> all outputs 0 asynchronously; after release FSM=IDLE with no done_o; a new job runs correctly.
- Two back-to-back jobs (k_len=2 then 5), second start the cycle after the first done_o -> cnt restarts at 0 and precision updates; total of 7 valid beats per row.
